// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Holds the FSM state enum, the RV32M funct3 encodings and the OP/funct7 decode constants.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/exe_muldiv_if.sv
// Control/data link between the muldiv FSM (master) and the iterative datapath (slave).
// load captures magnitudes and op kind; step advances one iteration; acc_nxt is the post-step value.
interface muldiv_iter_if;
  logic        load;
  logic        step;
  logic        is_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [63:0] acc_nxt;

  modport master (
    output load, step, is_div, op_a, op_b,
    input  acc_nxt
  );

  modport slave (
    input  load, step, is_div, op_a, op_b,
    output acc_nxt
  );
endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider on unsigned magnitudes, one step per cycle.
// acc holds {hi, lo}: product accumulator for multiply, {remainder, quotient} for divide.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  muldiv_iter_if.slave  it
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic        div_q, div_d;

  logic [32:0] mul_sum;
  logic [32:0] div_tmp;
  logic [32:0] div_diff;
  logic [63:0] step_val;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    // Shifted partial remainder; bit 32 of the difference flags tmp < divisor.
    div_tmp  = acc_q[63:31];
    div_diff = div_tmp - {1'b0, b_q};
    if (div_q) begin
      if (div_diff[32]) begin
        step_val = {div_tmp[31:0], acc_q[30:0], 1'b0};
      end else begin
        step_val = {div_diff[31:0], acc_q[30:0], 1'b1};
      end
    end else begin
      step_val = {mul_sum, acc_q[31:1]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    div_d = div_q;
    if (it.load) begin
      acc_d = {32'd0, it.op_a};
      b_d   = it.op_b;
      div_d = it.is_div;
    end else if (it.step) begin
      acc_d = step_val;
    end
  end

  assign it.acc_nxt = step_val;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= 64'd0;
      b_q   <= 32'd0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/exe_muldiv.sv
// RV32M execute-stage multiply/divide unit: IDLE/BUSY/DONE FSM, sign fixup and special cases.
// Define MULDIV_FAST_MUL_EN for a single-cycle registered 33x33 multiply; divides stay iterative.
module exe_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode_ID_EXE,
  input  logic [2:0]  funct3_ID_EXE,
  input  logic [6:0]  funct7,
  input  logic [4:0]  write_addr_ID_EXE,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        Istall,
  input  logic        flush,
  output logic        muldiv_stall,
  output logic        muldiv_valid,
  output logic [31:0] muldiv_result,
  output logic [4:0]  muldiv_wr_addr,
  output state_e      state_dbg_o
);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [4:0]  waddr_q;
  logic        neg_q;
  logic        rneg_q;
  logic        valid_q;
  logic [31:0] result_q;
  logic [4:0]  wr_addr_q;

  logic        start;
  logic        op_is_div;
  logic        a_sgn, b_sgn;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf;
  logic [31:0] special_res;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] iter_res;

  muldiv_iter_if iter_bus ();

  assign start = (state_q == ST_IDLE) && (opcode_ID_EXE == OPC_OP) &&
                 (funct7 == F7_MULDIV) && !flush;

  assign op_is_div = funct3_ID_EXE[2];
  assign a_sgn = op_is_div ? ~funct3_ID_EXE[0]
                           : ((funct3_ID_EXE == F3_MULH) || (funct3_ID_EXE == F3_MULHSU));
  assign b_sgn = op_is_div ? ~funct3_ID_EXE[0] : (funct3_ID_EXE == F3_MULH);
  assign a_neg = a_sgn & rs1_data[31];
  assign b_neg = b_sgn & rs2_data[31];
  assign mag_a = a_neg ? (32'd0 - rs1_data) : rs1_data;
  assign mag_b = b_neg ? (32'd0 - rs2_data) : rs2_data;

  // Cases the iterative divider would get wrong are resolved directly at start.
  assign div_zero = op_is_div && (rs2_data == 32'd0);
  assign div_ovf  = op_is_div && !funct3_ID_EXE[0] &&
                    (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  always_comb begin
    special_res = 32'd0;
    if (div_zero) begin
      special_res = funct3_ID_EXE[1] ? rs1_data : 32'hFFFF_FFFF;
    end else begin
      special_res = funct3_ID_EXE[1] ? 32'd0 : 32'h8000_0000;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [32:0] fast_a, fast_b;
  logic signed [65:0] fast_prod;
  logic [31:0]        fast_res;
  assign fast_a    = {a_sgn & rs1_data[31], rs1_data};
  assign fast_b    = {b_sgn & rs2_data[31], rs2_data};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (funct3_ID_EXE == F3_MUL) ? fast_prod[31:0] : fast_prod[63:32];
`endif

  assign iter_bus.load   = start;
  assign iter_bus.step   = (state_q == ST_BUSY);
  assign iter_bus.is_div = op_is_div;
  assign iter_bus.op_a   = mag_a;
  assign iter_bus.op_b   = mag_b;

  muldiv_iter u_iter (
    .clk (clk),
    .rst (rst),
    .it  (iter_bus)
  );

  // Result fixup works on the value the final iteration is about to store.
  assign prod_fix = neg_q ? (64'd0 - iter_bus.acc_nxt) : iter_bus.acc_nxt;
  assign quot_fix = neg_q ? (32'd0 - iter_bus.acc_nxt[31:0]) : iter_bus.acc_nxt[31:0];
  assign rem_fix  = rneg_q ? (32'd0 - iter_bus.acc_nxt[63:32]) : iter_bus.acc_nxt[63:32];

  always_comb begin
    iter_res = prod_fix[63:32];
    case (f3_q)
      F3_MUL:                  iter_res = prod_fix[31:0];
      F3_DIV, F3_DIVU:         iter_res = quot_fix;
      F3_REM, F3_REMU:         iter_res = rem_fix;
      default:                 iter_res = prod_fix[63:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      f3_q      <= 3'd0;
      waddr_q   <= 5'd0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= 32'd0;
      wr_addr_q <= 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            f3_q    <= funct3_ID_EXE;
            waddr_q <= write_addr_ID_EXE;
            cnt_q   <= 5'd0;
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            if (div_zero || div_ovf) begin
              state_q   <= ST_DONE;
              valid_q   <= 1'b1;
              result_q  <= special_res;
              wr_addr_q <= write_addr_ID_EXE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!op_is_div) begin
              state_q   <= ST_DONE;
              valid_q   <= 1'b1;
              result_q  <= fast_res;
              wr_addr_q <= write_addr_ID_EXE;
`endif
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q   <= ST_DONE;
              valid_q   <= 1'b1;
              result_q  <= iter_res;
              wr_addr_q <= waddr_q;
            end
          end
        end
        ST_DONE: begin
          // Istall freezes ID/EXE, so the result must stay presented until it can be captured.
          if (flush || !Istall) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign muldiv_stall   = rst & (start | (state_q == ST_BUSY));
  assign muldiv_valid   = valid_q;
  assign muldiv_result  = result_q;
  assign muldiv_wr_addr = wr_addr_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed RV32M cases, flush/Istall/reset scenarios, random ops.
// Expected {wr_addr, result} pairs come from a native-arithmetic reference model via a queue.
module tb_exe_muldiv;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam logic [6:0] OPC_NOP = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode_ID_EXE;
  logic [2:0]  funct3_ID_EXE;
  logic [6:0]  funct7;
  logic [4:0]  write_addr_ID_EXE;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        Istall;
  logic        flush;
  logic        muldiv_stall;
  logic        muldiv_valid;
  logic [31:0] muldiv_result;
  logic [4:0]  muldiv_wr_addr;
  state_e      state_dbg;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  exe_muldiv dut (
    .clk               (clk),
    .rst               (rst),
    .opcode_ID_EXE     (opcode_ID_EXE),
    .funct3_ID_EXE     (funct3_ID_EXE),
    .funct7            (funct7),
    .write_addr_ID_EXE (write_addr_ID_EXE),
    .rs1_data          (rs1_data),
    .rs2_data          (rs2_data),
    .Istall            (Istall),
    .flush             (flush),
    .muldiv_stall      (muldiv_stall),
    .muldiv_valid      (muldiv_valid),
    .muldiv_result     (muldiv_result),
    .muldiv_wr_addr    (muldiv_wr_addr),
    .state_dbg_o       (state_dbg)
  );

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    logic signed [31:0] s32a, s32b, sq;
    logic               ovf;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    s32a = a;
    s32b = b;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p    = 64'd0;
    sq   = 32'sd0;
    case (f3)
      F3_MUL:    begin p = ua * ub; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sq = s32a / s32b;
        return sq;
      end
      F3_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        sq = s32a % s32b;
        return sq;
      end
      default:   return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic drive_nop();
    opcode_ID_EXE = OPC_NOP;
    funct7        = 7'd0;
    funct3_ID_EXE = 3'd0;
    flush         = 1'b0;
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] addr);
    opcode_ID_EXE     = OPC_OP;
    funct7            = F7_MULDIV;
    funct3_ID_EXE     = f3;
    rs1_data          = a;
    rs2_data          = b;
    write_addr_ID_EXE = addr;
    flush             = 1'b0;
  endtask

  // Issue one op, wait for valid, check latency, stall length, result, then retire it.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr);
    int          k, stall_cnt, lat_exp;
    logic        special;
    logic [36:0] e;
    special = f3[2] && ((b == 32'd0) ||
              (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    lat_exp = special ? 1 : (f3[2] ? 33 : MUL_LAT);
    exp_q.push_back({addr, ref_res(f3, a, b)});
    @(negedge clk);
    drive_op(f3, a, b, addr);
    #1;
    k = 0;
    stall_cnt = 0;
    while ((k < 60) && !muldiv_valid) begin
      if (muldiv_stall) stall_cnt++;
      @(negedge clk);
      k++;
    end
    e = exp_q.pop_front();
    checks++;
    if (!muldiv_valid) begin
      errors++;
      $display("FAIL %s timeout: no muldiv_valid after %0d cycles, required at %0d", name, k, lat_exp);
    end else begin
      checks++;
      if (k !== lat_exp) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles, required %0d", name, k, lat_exp);
      end
      checks++;
      if (stall_cnt !== lat_exp) begin
        errors++;
        $display("FAIL %s stall_len: got %0d cycles, required %0d", name, stall_cnt, lat_exp);
      end
      checks++;
      if ({muldiv_wr_addr, muldiv_result} !== e) begin
        errors++;
        $display("FAIL %s result: got addr %0d data %h, required addr %0d data %h",
                 name, muldiv_wr_addr, muldiv_result, e[36:32], e[31:0]);
      end
      checks++;
      if (muldiv_stall !== 1'b0) begin
        errors++;
        $display("FAIL %s done_stall: got %b, required 0", name, muldiv_stall);
      end
    end
    drive_nop();
    @(negedge clk);
    checks++;
    if ({state_dbg, muldiv_valid, muldiv_result} !== {ST_IDLE, 1'b0, e[31:0]}) begin
      errors++;
      $display("FAIL %s retire: got state %0d valid %b data %h, required state 0 valid 0 data %h",
               name, state_dbg, muldiv_valid, muldiv_result, e[31:0]);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    Istall = 1'b0;
    drive_op(F3_MUL, 32'd3, 32'd5, 5'd9);
    repeat (3) @(negedge clk);
    checks++;
    if ({muldiv_stall, muldiv_valid, muldiv_result, muldiv_wr_addr, state_dbg} !==
        {1'b0, 1'b0, 32'd0, 5'd0, ST_IDLE}) begin
      errors++;
      $display("FAIL reset_state: got stall %b valid %b data %h addr %0d state %0d, required all 0",
               muldiv_stall, muldiv_valid, muldiv_result, muldiv_wr_addr, state_dbg);
    end
    drive_nop();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op("div_m7_2",     F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd1);
    do_op("rem_m7_2",     F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd2);
    do_op("divu_100_0",   F3_DIVU,   32'd100,       32'd0,         5'd3);
    do_op("remu_100_0",   F3_REMU,   32'd100,       32'd0,         5'd4);
    do_op("mulh_min_min", F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd5);
    do_op("div_ovf",      F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    do_op("rem_ovf",      F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    do_op("mulhsu_m1",    F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    do_op("mulhu_max",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    do_op("div_7_m2",     F3_DIV,    32'd7,         32'hFFFF_FFFE, 5'd10);
    do_op("rem_7_m2",     F3_REM,    32'd7,         32'hFFFF_FFFE, 5'd11);
    do_op("divu_max_3",   F3_DIVU,   32'hFFFF_FFFF, 32'd3,         5'd12);
    do_op("mul_neg",      F3_MUL,    32'hFFFF_FFFD, 32'd1000,      5'd13);
  endtask

  task automatic test_non_m();
    logic [6:0] opc_t [4];
    logic [6:0] f7_t  [4];
    opc_t = '{OPC_OP, OPC_OP, 7'b0010011, 7'b0000011};
    f7_t  = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b0000001};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_op(F3_DIV, 32'd50, 32'd5, 5'd20);
      opcode_ID_EXE = opc_t[i];
      funct7        = f7_t[i];
      #1;
      checks++;
      if (muldiv_stall !== 1'b0) begin
        errors++;
        $display("FAIL non_m_stall[%0d]: got %b, required 0", i, muldiv_stall);
      end
      @(negedge clk);
      checks++;
      if ({state_dbg, muldiv_valid} !== {ST_IDLE, 1'b0}) begin
        errors++;
        $display("FAIL non_m_idle[%0d]: got state %0d valid %b, required 0 0", i, state_dbg, muldiv_valid);
      end
    end
    drive_nop();
  endtask

  task automatic test_flush();
    int vcnt;
    // Flush coincident with the start cycle must suppress the start.
    @(negedge clk);
    drive_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd14);
    flush = 1'b1;
    #1;
    checks++;
    if (muldiv_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_stall: got %b, required 0", muldiv_stall);
    end
    @(negedge clk);
    checks++;
    if ({state_dbg, muldiv_valid} !== {ST_IDLE, 1'b0}) begin
      errors++;
      $display("FAIL flush_start_idle: got state %0d valid %b, required 0 0", state_dbg, muldiv_valid);
    end
    // Flush pulse at T+10 of a running DIV.
    drive_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd14);
    repeat (10) @(negedge clk);
    checks++;
    if (state_dbg !== ST_BUSY) begin
      errors++;
      $display("FAIL flush_busy: got state %0d, required %0d", state_dbg, ST_BUSY);
    end
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({state_dbg, muldiv_valid, muldiv_stall} !== {ST_IDLE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL flush_abort: got state %0d valid %b stall %b, required 0 0 0",
               state_dbg, muldiv_valid, muldiv_stall);
    end
    drive_nop();
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (muldiv_valid || muldiv_stall) vcnt++;
    end
    checks++;
    if (vcnt !== 0) begin
      errors++;
      $display("FAIL flush_quiet: got %0d active cycles, required 0", vcnt);
    end
  endtask

  // Istall raised as DONE is entered (cycles T+32..T+34): valid must be seen for exactly 3 cycles.
  task automatic test_istall();
    int          vcnt, act;
    logic [36:0] e;
    exp_q.push_back({5'd21, ref_res(F3_DIV, 32'd1000, 32'd7)});
    @(negedge clk);
    drive_op(F3_DIV, 32'd1000, 32'd7, 5'd21);
    repeat (32) @(negedge clk);
    Istall = 1'b1;
    vcnt = 0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({muldiv_valid, muldiv_wr_addr, muldiv_result} !== {1'b1, e}) begin
      errors++;
      $display("FAIL istall_result: got valid %b addr %0d data %h, required 1 %0d %h",
               muldiv_valid, muldiv_wr_addr, muldiv_result, e[36:32], e[31:0]);
    end
    if (muldiv_valid) vcnt++;
    @(negedge clk);
    if (muldiv_valid) vcnt++;
    @(negedge clk);
    if (muldiv_valid) vcnt++;
    Istall = 1'b0;
    drive_nop();
    @(negedge clk);
    if (muldiv_valid) vcnt++;
    checks++;
    if ({state_dbg, vcnt} !== {ST_IDLE, 32'd3}) begin
      errors++;
      $display("FAIL istall_hold: got state %0d valid_cycles %0d, required state 0 cycles 3",
               state_dbg, vcnt);
    end
    act = 0;
    repeat (5) begin
      @(negedge clk);
      if (muldiv_valid || muldiv_stall) act++;
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL istall_restart: got %0d active cycles, required 0", act);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_op(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({muldiv_stall, muldiv_valid, muldiv_result, muldiv_wr_addr, state_dbg} !==
        {1'b0, 1'b0, 32'd0, 5'd0, ST_IDLE}) begin
      errors++;
      $display("FAIL reset_mid: got stall %b valid %b data %h addr %0d state %0d, required all 0",
               muldiv_stall, muldiv_valid, muldiv_result, muldiv_wr_addr, state_dbg);
    end
    rst = 1'b1;
    drive_nop();
    do_op("mul_6x7_after_reset", F3_MUL, 32'd6, 32'd7, 5'd18);
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      do_op($sformatf("rand%0d_f3_%0d", i, f3), f3, a, b, 5'($urandom_range(1, 31)));
    end
  endtask

  initial begin
    opcode_ID_EXE     = OPC_NOP;
    funct3_ID_EXE     = 3'd0;
    funct7            = 7'd0;
    write_addr_ID_EXE = 5'd0;
    rs1_data          = 32'd0;
    rs2_data          = 32'd0;
    Istall            = 1'b0;
    flush             = 1'b0;
    rst               = 1'b0;
    test_reset();
    test_directed();
    test_non_m();
    test_flush();
    test_istall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
